// File: rtl/adder_defs.sv
// Shared definitions for the adder operand sequencer slice.
// Widths, FSM encoding and small helpers.
package adder_defs;

    localparam int WIDTH     = 4;
    localparam int OVF_CNT_W = 8;
    localparam int CNT_W     = 4;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETTLE = 2'd1,
        DONE   = 2'd2
    } state_t;

    // Saturating increment: an all-ones count stays put.
    function automatic logic [OVF_CNT_W-1:0] sat_inc(
        input logic [OVF_CNT_W-1:0] v
    );
        return (&v) ? v : v + 1'b1;
    endfunction

endpackage

// File: rtl/settle_counter.sv
// Loadable down-counter with a zero flag.
// Times gate-delay settling for multi-cycle stages.
module settle_counter
    import adder_defs::*;
(
    input  logic             clk,
    input  logic             reset,
    input  logic             load,
    input  logic [CNT_W-1:0] load_val,
    input  logic             dec,
    output logic             zero
);

    logic [CNT_W-1:0] count;

    assign zero = (count == '0);

    // Load has priority; decrement stops at zero.
    always_ff @(posedge clk) begin
        if (reset) begin
            count <= '0;
        end else if (load) begin
            count <= load_val;
        end else if (dec && !zero) begin
            count <= count - 1'b1;
        end
    end

endmodule

// File: rtl/adder_operand_sequencer.sv
// Holds operands on an external ripple adder, waits for it
// to settle, then captures and hands off the result.
module adder_operand_sequencer
    import adder_defs::*;
#(
    parameter int SETTLE_CYCLES = 4
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [WIDTH-1:0]     in_a,
    input  logic [WIDTH-1:0]     in_b,
    input  logic                 in_acc,
    output logic [WIDTH-1:0]     adder_a,
    output logic [WIDTH-1:0]     adder_b,
    input  logic [WIDTH-1:0]     adder_sum,
    input  logic                 adder_carryout,
    input  logic                 adder_overflow,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [WIDTH-1:0]     out_sum,
    output logic                 out_carryout,
    output logic                 out_overflow,
    output logic [WIDTH-1:0]     acc,
    output logic [OVF_CNT_W-1:0] ovf_count
);

    localparam logic [CNT_W-1:0] LOAD_VAL =
        CNT_W'(SETTLE_CYCLES - 1);

    state_t state_q;
    state_t state_d;
    logic   accept;
    logic   capture;
    logic   cnt_zero;

    settle_counter u_settle (
        .clk      (clk),
        .reset    (reset),
        .load     (accept),
        .load_val (LOAD_VAL),
        .dec      (state_q == SETTLE),
        .zero     (cnt_zero)
    );

    // State register.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state, handshake outputs and datapath strobes.
    always_comb begin
        state_d   = state_q;
        accept    = 1'b0;
        capture   = 1'b0;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        unique case (state_q)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    accept  = 1'b1;
                    state_d = SETTLE;
                end
            end
            SETTLE: begin
                if (cnt_zero) begin
                    capture = 1'b1;
                    state_d = DONE;
                end
            end
            DONE: begin
                out_valid = 1'b1;
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Operand registers: held from accept until next accept.
    always_ff @(posedge clk) begin
        if (reset) begin
            adder_a <= '0;
            adder_b <= '0;
        end else if (accept) begin
            adder_a <= in_acc ? acc : in_a;
            adder_b <= in_b;
        end
    end

    // Result capture, accumulator and overflow-event count.
    always_ff @(posedge clk) begin
        if (reset) begin
            out_sum      <= '0;
            out_carryout <= 1'b0;
            out_overflow <= 1'b0;
            acc          <= '0;
            ovf_count    <= '0;
        end else if (capture) begin
            out_sum      <= adder_sum;
            out_carryout <= adder_carryout;
            out_overflow <= adder_overflow;
            acc          <= adder_sum;
            if (adder_overflow) begin
                ovf_count <= sat_inc(ovf_count);
            end
        end
    end

endmodule

// File: tb/tb_adder_operand_sequencer.sv
// Bench for adder_operand_sequencer with a stand-in adder
// and a queue of expected results.
module tb_adder_operand_sequencer;

    localparam int S = 4;

    typedef struct {
        logic [3:0] sum;
        logic       cout;
        logic       ovf;
    } exp_t;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       in_valid = 1'b0;
    logic       in_ready;
    logic [3:0] in_a = '0;
    logic [3:0] in_b = '0;
    logic       in_acc = 1'b0;
    logic [3:0] adder_a, adder_b, adder_sum;
    logic       adder_carryout, adder_overflow;
    logic       out_valid;
    logic       out_ready = 1'b0;
    logic [3:0] out_sum;
    logic       out_carryout, out_overflow;
    logic [3:0] acc;
    logic [7:0] ovf_count;

    logic       in_valid1 = 1'b0;
    logic       in_ready1;
    logic [3:0] in_a1 = '0;
    logic [3:0] in_b1 = '0;
    logic [3:0] adder_a1, adder_b1, adder_sum1;
    logic       adder_carryout1, adder_overflow1;
    logic       out_valid1;
    logic       out_ready1 = 1'b0;
    logic [3:0] out_sum1;
    logic       out_carryout1, out_overflow1;
    logic [3:0] acc1;
    logic [7:0] ovf_count1;

    exp_t       scb[$];
    logic [3:0] m_acc = '0;
    int         m_ovf = 0;
    int         errors = 0;
    int         checks = 0;

    always #5 clk = ~clk;

    // Stand-in for the external FullAdder4bit.
    assign {adder_carryout, adder_sum} = 5'(adder_a) + 5'(adder_b);
    assign adder_overflow = (adder_a[3] == adder_b[3]) &&
                            (adder_sum[3] != adder_a[3]);
    assign {adder_carryout1, adder_sum1} =
        5'(adder_a1) + 5'(adder_b1);
    assign adder_overflow1 = (adder_a1[3] == adder_b1[3]) &&
                             (adder_sum1[3] != adder_a1[3]);

    adder_operand_sequencer #(.SETTLE_CYCLES(S)) dut (
        .clk(clk), .reset(reset),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_a(in_a), .in_b(in_b), .in_acc(in_acc),
        .adder_a(adder_a), .adder_b(adder_b),
        .adder_sum(adder_sum),
        .adder_carryout(adder_carryout),
        .adder_overflow(adder_overflow),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_sum(out_sum), .out_carryout(out_carryout),
        .out_overflow(out_overflow),
        .acc(acc), .ovf_count(ovf_count)
    );

    adder_operand_sequencer #(.SETTLE_CYCLES(1)) dut1 (
        .clk(clk), .reset(reset),
        .in_valid(in_valid1), .in_ready(in_ready1),
        .in_a(in_a1), .in_b(in_b1), .in_acc(1'b0),
        .adder_a(adder_a1), .adder_b(adder_b1),
        .adder_sum(adder_sum1),
        .adder_carryout(adder_carryout1),
        .adder_overflow(adder_overflow1),
        .out_valid(out_valid1), .out_ready(out_ready1),
        .out_sum(out_sum1), .out_carryout(out_carryout1),
        .out_overflow(out_overflow1),
        .acc(acc1), .ovf_count(ovf_count1)
    );

    // Reference arithmetic via integer and signed-range math.
    function automatic exp_t model(input logic [3:0] a,
                                   input logic [3:0] b);
        exp_t e;
        int ua, ub, sa, sb, ss;
        ua = int'(a);
        ub = int'(b);
        sa = a[3] ? ua - 16 : ua;
        sb = b[3] ? ub - 16 : ub;
        ss = sa + sb;
        e.sum  = 4'(ua + ub);
        e.cout = (ua + ub) > 15;
        e.ovf  = (ss > 7) || (ss < -8);
        return e;
    endfunction

    task automatic model_capture(input exp_t e);
        m_acc = e.sum;
        if (e.ovf && m_ovf < 255) m_ovf++;
    endtask

    // Starts at a negedge; ends at the negedge after accept.
    task automatic accept_op(input logic [3:0] a,
                             input logic [3:0] b,
                             input logic ac);
        logic [3:0] aeff;
        int n;
        n = 0;
        in_a = a; in_b = b; in_acc = ac; in_valid = 1'b1;
        while (!in_ready && n < 100) begin
            @(negedge clk); n++;
        end
        if (!in_ready) begin
            errors++; checks++;
            $display("FAIL accept_timeout: in_ready=%b want 1",
                     in_ready);
            in_valid = 1'b0;
            return;
        end
        aeff = ac ? m_acc : a;
        scb.push_back(model(aeff, b));
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        checks++;
        if (adder_a !== aeff || adder_b !== b) begin
            errors++;
            $display("FAIL operands: got a=%b b=%b want a=%b b=%b",
                     adder_a, adder_b, aeff, b);
        end
    endtask

    task automatic finish_op();
        exp_t e;
        int lat;
        lat = 0;
        while (!out_valid && lat < 50) begin
            @(negedge clk); lat++;
        end
        checks++;
        if (lat !== S) begin
            errors++;
            $display("FAIL latency: got %0d want %0d", lat, S);
        end
        if (!out_valid || scb.size() == 0) return;
        e = scb.pop_front();
        checks++;
        if (out_sum !== e.sum || out_carryout !== e.cout ||
            out_overflow !== e.ovf) begin
            errors++;
            $display("FAIL result: got %b/%b/%b want %b/%b/%b",
                     out_sum, out_carryout, out_overflow,
                     e.sum, e.cout, e.ovf);
        end
        model_capture(e);
        checks++;
        if (acc !== m_acc || ovf_count !== m_ovf[7:0]) begin
            errors++;
            $display("FAIL acc_ovf: got %b/%0d want %b/%0d",
                     acc, ovf_count, m_acc, m_ovf);
        end
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            errors++;
            $display("FAIL release: got ov=%b ir=%b want 0/1",
                     out_valid, in_ready);
        end
    endtask

    task automatic do_op(input logic [3:0] a,
                         input logic [3:0] b,
                         input logic ac);
        accept_op(a, b, ac);
        finish_op();
    endtask

    task automatic check_reset_state(input string tag);
        logic [27:0] v;
        v = {in_ready, out_valid, adder_a, adder_b, out_sum,
             out_carryout, out_overflow, acc, ovf_count};
        checks++;
        if (v !== {1'b1, 27'd0}) begin
            errors++;
            $display("FAIL %s: got %h want %h", tag, v,
                     {1'b1, 27'd0});
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        check_reset_state("reset_values");
    endtask

    task automatic test_basic();
        do_op(4'b0101, 4'b0110, 1'b0);
        checks++;
        if (acc !== 4'b1011 || ovf_count !== 8'd1) begin
            errors++;
            $display("FAIL basic: got acc=%b cnt=%0d want 1011/1",
                     acc, ovf_count);
        end
    endtask

    task automatic test_carry();
        do_op(4'b1110, 4'b1101, 1'b0);
        checks++;
        if (out_sum !== 4'b1011 || out_carryout !== 1'b1) begin
            errors++;
            $display("FAIL carry: got %b/%b want 1011/1",
                     out_sum, out_carryout);
        end
    endtask

    task automatic test_chain();
        do_op(4'b0001, 4'b0001, 1'b0);
        accept_op(4'b1111, 4'b0011, 1'b1);
        checks++;
        if (adder_a !== 4'b0010) begin
            errors++;
            $display("FAIL chain_a: got %b want 0010", adder_a);
        end
        finish_op();
        checks++;
        if (acc !== 4'b0101) begin
            errors++;
            $display("FAIL chain_acc: got %b want 0101", acc);
        end
    endtask

    task automatic test_backpressure();
        exp_t e;
        int n;
        accept_op(4'b0011, 4'b0010, 1'b0);
        n = 0;
        while (!out_valid && n < 50) begin
            @(negedge clk); n++;
        end
        if (!out_valid || scb.size() == 0) begin
            errors++; checks++;
            $display("FAIL bp_wait: out_valid=%b want 1", out_valid);
            return;
        end
        in_a = 4'b1000; in_b = 4'b0001; in_acc = 1'b0;
        in_valid = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            checks++;
            if (in_ready !== 1'b0 || out_valid !== 1'b1 ||
                out_sum !== scb[0].sum ||
                out_carryout !== scb[0].cout ||
                out_overflow !== scb[0].ovf ||
                adder_a !== 4'b0011 || adder_b !== 4'b0010) begin
                errors++;
                $display("FAIL bp_hold: got ir=%b ov=%b s=%b a=%b b=%b want 0/1/%b/0011/0010",
                         in_ready, out_valid, out_sum, adder_a,
                         adder_b, scb[0].sum);
            end
        end
        e = scb.pop_front();
        model_capture(e);
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        checks++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
            errors++;
            $display("FAIL bp_release: got ir=%b ov=%b want 1/0",
                     in_ready, out_valid);
        end
        scb.push_back(model(4'b1000, 4'b0001));
        @(negedge clk);
        in_valid = 1'b0;
        checks++;
        if (adder_a !== 4'b1000 || adder_b !== 4'b0001) begin
            errors++;
            $display("FAIL bp_next: got %b/%b want 1000/0001",
                     adder_a, adder_b);
        end
        finish_op();
    endtask

    task automatic test_reset_mid();
        accept_op(4'b0111, 4'b0001, 1'b0);
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        check_reset_state("reset_mid_settle");
        scb.delete();
        m_acc = '0;
        m_ovf = 0;
        do_op(4'b0010, 4'b0011, 1'b0);
    endtask

    task automatic test_back_to_back();
        exp_t e;
        int accepts, pops, last;
        accepts = 0; pops = 0; last = -1;
        in_a = 4'b0000; in_b = 4'b0001; in_acc = 1'b1;
        in_valid = 1'b1; out_ready = 1'b1;
        for (int i = 0; i < 3 * (S + 2); i++) begin
            if (out_valid && scb.size() > 0) begin
                e = scb.pop_front();
                pops++;
                checks++;
                if (out_sum !== e.sum) begin
                    errors++;
                    $display("FAIL b2b_sum: got %b want %b",
                             out_sum, e.sum);
                end
                model_capture(e);
            end
            if (in_ready) begin
                if (last >= 0) begin
                    checks++;
                    if (i - last !== S + 2) begin
                        errors++;
                        $display("FAIL b2b_gap: got %0d want %0d",
                                 i - last, S + 2);
                    end
                end
                last = i;
                accepts++;
                scb.push_back(model(m_acc, 4'b0001));
            end
            @(negedge clk);
        end
        in_valid = 1'b0;
        for (int i = 0; i < 3 * (S + 2) && scb.size() > 0; i++) begin
            if (out_valid) begin
                e = scb.pop_front();
                pops++;
                checks++;
                if (out_sum !== e.sum) begin
                    errors++;
                    $display("FAIL b2b_sum: got %b want %b",
                             out_sum, e.sum);
                end
                model_capture(e);
            end
            @(negedge clk);
        end
        out_ready = 1'b0;
        in_acc = 1'b0;
        checks++;
        if (accepts !== 3 || pops !== 3 || acc !== m_acc) begin
            errors++;
            $display("FAIL b2b_count: got acc=%0d pop=%0d sum=%b want 3/3/%b",
                     accepts, pops, acc, m_acc);
        end
    endtask

    task automatic test_saturation();
        for (int i = 0; i < 300; i++) begin
            do_op(4'b0111, 4'b0011, 1'b0);
        end
        checks++;
        if (ovf_count !== 8'd255 || out_sum !== 4'b1010) begin
            errors++;
            $display("FAIL saturate: got %0d/%b want 255/1010",
                     ovf_count, out_sum);
        end
    endtask

    task automatic test_settle_one();
        in_a1 = 4'b0011; in_b1 = 4'b0100; in_valid1 = 1'b1;
        @(negedge clk);
        in_valid1 = 1'b0;
        checks++;
        if (in_ready1 !== 1'b0 || out_valid1 !== 1'b0) begin
            errors++;
            $display("FAIL s1_settle: got ir=%b ov=%b want 0/0",
                     in_ready1, out_valid1);
        end
        @(negedge clk);
        checks++;
        if (out_valid1 !== 1'b1 || out_sum1 !== 4'b0111 ||
            acc1 !== 4'b0111) begin
            errors++;
            $display("FAIL s1_capture: got ov=%b s=%b want 1/0111",
                     out_valid1, out_sum1);
        end
        out_ready1 = 1'b1;
        @(negedge clk);
        out_ready1 = 1'b0;
        checks++;
        if (out_valid1 !== 1'b0 || in_ready1 !== 1'b1) begin
            errors++;
            $display("FAIL s1_release: got ov=%b ir=%b want 0/1",
                     out_valid1, in_ready1);
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_carry();
        test_chain();
        test_backpressure();
        test_reset_mid();
        test_back_to_back();
        test_settle_one();
        test_saturation();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

endmodule
